control_sequencer: RTL and testbench
====================================

# control_sequencer

Microcoded control unit for the SAP core: a step counter (T0–T4) plus opcode decode that drives every load/enable strobe on the shared 8-bit bus. It sits directly upstream of the RAM/MAR stage and sources `load_addr_reg`, `output_enable` and the RAM write strobe (`control_signal`). It also drives PC, IR, A/B registers, ALU and output register.

## Interface
- `LAST_STEP`, default 4: index of the final microstep. Fixed at 4 for this ISA; it is a parameter only to size the counter.
- `clk` in 1: system clock. Step advances on the rising edge.
- `clear_n` in 1: synchronous, active-low reset.
- `run` in 1: 1 = run mode; 0 = program mode, with RAM loaded from the dipswitches.
- `opcode` in 4: IR[7:4].
- `carry_flag`, `zero_flag` in 1 each: registered ALU flags.
- `step` out 3: current microstep, for LEDs.
- `halted` out 1: halt latch.
- Control word out, 1 bit each:
  - `hlt`
  - `mi` (MAR load, goes to `load_addr_reg`)
  - `ri` (RAM write, goes to `control_signal`)
  - `ro` (RAM out, goes to `output_enable`)
  - `io` (IR low nibble out)
  - `ii` (IR in)
  - `ai`, `ao` (A in/out)
  - `eo` (ALU out)
  - `su` (ALU subtract)
  - `bi` (B in)
  - `oi` (output register in)
  - `ce` (PC increment)
  - `co` (PC out)
  - `j` (PC load)
  - `fi` (flags in)

## Operation
- Control word is a combinational function of (`step`, `opcode`, flags, `halted`, `run`), with no added latency. Downstream registers sample it on the next rising edge.
- Fetch, for every opcode:
  - T0: `co mi`
  - T1: `ro ii ce`
- Execute:
  - LDA 0001: T2 `io mi`; T3 `ro ai`.
  - ADD 0010: T2 `io mi`; T3 `ro bi`; T4 `eo ai fi`.
  - SUB 0011: as ADD, plus `su` in T4.
  - STA 0100: T2 `io mi`; T3 `ao ri`.
  - LDI 0101: T2 `io ai`.
  - JMP 0110: T2 `io j`.
  - JC 0111: T2 `io j` if `carry_flag`, else empty.
  - JZ 1000: T2 `io j` if `zero_flag`, else empty.
  - OUT 1110: T2 `ao oi`.
  - HLT 1111: T2 `hlt`.
  - NOP 0000 and undefined opcodes: no execute signals.
- Early termination: after the last non-empty step of an instruction, `step` returns to 0 on the next edge.
  - Instruction lengths: NOP/undefined/not-taken jump 3 cycles, since T2 is empty and step wraps after T2.
  - LDI/JMP/taken jump/OUT 3 cycles; LDA/STA 4; ADD/SUB 5.
  - Step never exceeds `LAST_STEP`.
- Flags are sampled at T2 only.
- Halt: `halted` sets on the edge ending HLT T2.
  - While `halted`=1: `step` is frozen at 0, all control outputs are 0 except `hlt`=1.
  - Only `clear_n` clears it.
- Program mode: `run`=0 forces `step` to 0 on the next edge and all control outputs to 0 combinationally. This frees RAM for dipswitch writes.
  - Returning `run` to 1 starts a fresh fetch at T0.
  - `halted` is unaffected by `run`.
- Bus discipline: at most one of `ro io ao eo co` is asserted in any cycle. The bench checks this every cycle.

## Timing
- Reset: `clear_n`=0 at a rising edge sets `step`=0 and `halted`=0.
  - While reset is held, all control outputs are 0.
  - Reset mid-instruction aborts it with no partial strobes afterwards.
- Outputs after release: T0 fetch signals (`co mi`) appear in the first cycle after the reset edge, provided `run`=1.
- Simultaneous events:
  - `clear_n`=0 overrides `run` and halt.
  - `run`=0 overrides step advance, but `halted` keeps `hlt`=1 if it is set.
- Opcode is assumed stable from T2 onward; it is loaded by `ii` at the T1 edge.

## Structure
- Shared package `sap_pkg` holds:
  - opcode constants (`OP_NOP` … `OP_HLT`)
  - step constants `T0`–`T4`
  - control-word bit-index constants, so RAM/ALU/PC blocks use the same names.
- Sub-module `step_counter`: 3-bit counter with synchronous clear, hold and `wrap` inputs. The top level holds the decode ROM and halt latch.

## Test plan
- Reset then `run`=1, opcode 0001 (LDA):
  - `step` sequence is 0,1,2,3,0.
  - Strobes per step: T0 `co mi`, T1 `ro ii ce`, T2 `io mi`, T3 `ro ai`.
- Opcode 0011 (SUB): T4 shows `eo ai fi su`=1 and the next step is 0; 5-cycle period.
- Opcode 0111 (JC):
  - With `carry_flag`=1: `j io` at T2.
  - With `carry_flag`=0: T2 all-zero and wrap to 0.
  - Both cases take 3 cycles.
- Opcode 1111 (HLT):
  - `halted`=1 from the cycle after T2; `step` stuck at 0; only `hlt` high for 20 cycles.
  - Then `clear_n` pulse returns to T0 fetch.
- Drop `run` to 0 during ADD T3: next cycle `step`=0 with all outputs 0; raise `run` and a normal fetch follows.
- Assert `clear_n`=0 during STA T3 with `ri` high: `ri` is low in that cycle and `step`=0 after the edge; random-opcode run of 1000 cycles shows the one-bus-driver check never fails.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: names shared by every block of the SAP core.
//   - Opcode constants for IR[7:4].
//   - Microstep constants T0..T4.
//   - Control-word bit indices. The RAM, ALU and PC blocks use these same
//     indices, so a packed control word means the same thing everywhere.
package sap_pkg;

   // Opcodes (IR[7:4])
   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // Microsteps
   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;

   // Control-word bit indices
   localparam int CW_W   = 16;
   localparam int CW_HLT = 15;
   localparam int CW_MI  = 14;
   localparam int CW_RI  = 13;
   localparam int CW_RO  = 12;
   localparam int CW_IO  = 11;
   localparam int CW_II  = 10;
   localparam int CW_AI  = 9;
   localparam int CW_AO  = 8;
   localparam int CW_EO  = 7;
   localparam int CW_SU  = 6;
   localparam int CW_BI  = 5;
   localparam int CW_OI  = 4;
   localparam int CW_CE  = 3;
   localparam int CW_CO  = 2;
   localparam int CW_J   = 1;
   localparam int CW_FI  = 0;

   typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/step_counter.sv
// step_counter: 3-bit microstep counter for the SAP control sequencer.
// Ports:
//   clk_i    system clock, counts on the rising edge
//   rst_ni   synchronous active-low reset, forces the count to 0
//   clr_i    synchronous clear to 0 (program mode)
//   hold_i   freeze the current count (halted)
//   wrap_i   current step is the last one of the instruction; go to 0 next
//   step_o   current microstep
// Priority: reset > clear > hold > wrap > increment. The count also wraps
// unconditionally at LAST_STEP so it can never run past the final step.
module step_counter #(
   parameter int LAST_STEP = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       hold_i,
   input  logic       wrap_i,
   output logic [2:0] step_o
);

   logic [2:0] step_q;
   logic [2:0] step_d;

   always_comb begin
      step_d = step_q;
      if (clr_i) begin
         step_d = 3'd0;
      end else if (hold_i) begin
         step_d = step_q;
      end else if (wrap_i || (step_q >= 3'(LAST_STEP))) begin
         step_d = 3'd0;
      end else begin
         step_d = step_q + 3'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         step_q <= 3'd0;
      end else begin
         step_q <= step_d;
      end
   end

   assign step_o = step_q;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit of the SAP core.
// Holds the decode ROM (step x opcode x flags -> control word) and the halt
// latch; the microstep itself lives in step_counter.
// Ports:
//   clk                  system clock
//   clear_n              synchronous active-low reset
//   run                  1 = run mode, 0 = program mode (RAM fed by dipswitches)
//   opcode[3:0]          IR[7:4]
//   carry_flag/zero_flag registered ALU flags, consulted at T2 only
//   step[2:0]            current microstep (LEDs, debug)
//   halted               halt latch
//   hlt mi ri ro io ii ai ao eo su bi oi ce co j fi   control word strobes
// The control word is purely combinational from the current step, opcode,
// flags, halt latch, run and clear_n; downstream registers sample it on the
// next rising edge.
module control_sequencer
   import sap_pkg::*;
#(
   parameter int LAST_STEP = 4
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic       run,
   input  logic [3:0] opcode,
   input  logic       carry_flag,
   input  logic       zero_flag,
   output logic [2:0] step,
   output logic       halted,
   output logic       hlt,
   output logic       mi,
   output logic       ri,
   output logic       ro,
   output logic       io,
   output logic       ii,
   output logic       ai,
   output logic       ao,
   output logic       eo,
   output logic       su,
   output logic       bi,
   output logic       oi,
   output logic       ce,
   output logic       co,
   output logic       j,
   output logic       fi
);

   logic [2:0] step_q;
   logic       halted_q;
   logic       halted_d;
   cw_t        rom_cw;    // raw decode ROM output
   logic       rom_last;  // current step is the last non-empty one
   cw_t        cw;        // after reset / halt / program-mode gating

   step_counter #(
      .LAST_STEP (LAST_STEP)
   ) u_step_counter (
      .clk_i  (clk),
      .rst_ni (clear_n),
      .clr_i  (!run),
      .hold_i (halted_q),
      .wrap_i (rom_last),
      .step_o (step_q)
   );

   // Decode ROM. Empty steps (NOP, undefined opcodes, not-taken jumps)
   // mark themselves as last so the step wraps right after T2.
   always_comb begin
      rom_cw   = '0;
      rom_last = 1'b0;
      unique case (step_q)
         T0: begin
            rom_cw[CW_CO] = 1'b1;
            rom_cw[CW_MI] = 1'b1;
         end
         T1: begin
            rom_cw[CW_RO] = 1'b1;
            rom_cw[CW_II] = 1'b1;
            rom_cw[CW_CE] = 1'b1;
         end
         T2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  rom_cw[CW_IO] = 1'b1;
                  rom_cw[CW_MI] = 1'b1;
               end
               OP_LDI: begin
                  rom_cw[CW_IO] = 1'b1;
                  rom_cw[CW_AI] = 1'b1;
                  rom_last      = 1'b1;
               end
               OP_JMP: begin
                  rom_cw[CW_IO] = 1'b1;
                  rom_cw[CW_J]  = 1'b1;
                  rom_last      = 1'b1;
               end
               OP_JC: begin
                  rom_cw[CW_IO] = carry_flag;
                  rom_cw[CW_J]  = carry_flag;
                  rom_last      = 1'b1;
               end
               OP_JZ: begin
                  rom_cw[CW_IO] = zero_flag;
                  rom_cw[CW_J]  = zero_flag;
                  rom_last      = 1'b1;
               end
               OP_OUT: begin
                  rom_cw[CW_AO] = 1'b1;
                  rom_cw[CW_OI] = 1'b1;
                  rom_last      = 1'b1;
               end
               OP_HLT: begin
                  rom_cw[CW_HLT] = 1'b1;
                  rom_last       = 1'b1;
               end
               default: rom_last = 1'b1;
            endcase
         end
         T3: begin
            case (opcode)
               OP_LDA: begin
                  rom_cw[CW_RO] = 1'b1;
                  rom_cw[CW_AI] = 1'b1;
                  rom_last      = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rom_cw[CW_RO] = 1'b1;
                  rom_cw[CW_BI] = 1'b1;
               end
               OP_STA: begin
                  rom_cw[CW_AO] = 1'b1;
                  rom_cw[CW_RI] = 1'b1;
                  rom_last      = 1'b1;
               end
               default: rom_last = 1'b1;
            endcase
         end
         T4: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               rom_cw[CW_EO] = 1'b1;
               rom_cw[CW_AI] = 1'b1;
               rom_cw[CW_FI] = 1'b1;
               rom_cw[CW_SU] = (opcode == OP_SUB);
            end
            rom_last = 1'b1;
         end
         default: rom_last = 1'b1;
      endcase
   end

   // Reset beats halt beats program mode. A halted core keeps hlt high even
   // in program mode so the halt LED stays lit.
   always_comb begin
      cw = '0;
      if (!clear_n) begin
         cw = '0;
      end else if (halted_q) begin
         cw[CW_HLT] = 1'b1;
      end else if (!run) begin
         cw = '0;
      end else begin
         cw = rom_cw;
      end
   end

   // The latch sets on the edge that ends HLT T2; only clear_n releases it.
   always_comb begin
      halted_d = halted_q;
      if (run && !halted_q && (step_q == T2) && (opcode == OP_HLT)) begin
         halted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign step   = step_q;
   assign halted = halted_q;
   assign hlt    = cw[CW_HLT];
   assign mi     = cw[CW_MI];
   assign ri     = cw[CW_RI];
   assign ro     = cw[CW_RO];
   assign io     = cw[CW_IO];
   assign ii     = cw[CW_II];
   assign ai     = cw[CW_AI];
   assign ao     = cw[CW_AO];
   assign eo     = cw[CW_EO];
   assign su     = cw[CW_SU];
   assign bi     = cw[CW_BI];
   assign oi     = cw[CW_OI];
   assign ce     = cw[CW_CE];
   assign co     = cw[CW_CO];
   assign j      = cw[CW_J];
   assign fi     = cw[CW_FI];

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed vector table plus hand-written
// sequences for halt, program mode, mid-instruction reset and a random run
// with the one-bus-driver check every cycle.
module tb_control_sequencer;

   // Bench-side control-word packing: {hlt,mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,fi}
   localparam logic [15:0] M_HLT = 16'h8000;
   localparam logic [15:0] M_MI  = 16'h4000;
   localparam logic [15:0] M_RI  = 16'h2000;
   localparam logic [15:0] M_RO  = 16'h1000;
   localparam logic [15:0] M_IO  = 16'h0800;
   localparam logic [15:0] M_II  = 16'h0400;
   localparam logic [15:0] M_AI  = 16'h0200;
   localparam logic [15:0] M_AO  = 16'h0100;
   localparam logic [15:0] M_EO  = 16'h0080;
   localparam logic [15:0] M_SU  = 16'h0040;
   localparam logic [15:0] M_BI  = 16'h0020;
   localparam logic [15:0] M_OI  = 16'h0010;
   localparam logic [15:0] M_CE  = 16'h0008;
   localparam logic [15:0] M_CO  = 16'h0004;
   localparam logic [15:0] M_J   = 16'h0002;
   localparam logic [15:0] M_FI  = 16'h0001;

   localparam logic [15:0] FETCH0 = M_CO | M_MI;
   localparam logic [15:0] FETCH1 = M_RO | M_II | M_CE;

   logic       clk;
   logic       clear_n;
   logic       run;
   logic [3:0] opcode;
   logic       carry_flag;
   logic       zero_flag;
   logic [2:0] step;
   logic       halted;
   logic       hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
   logic [15:0] cw_w;

   assign cw_w = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

   control_sequencer #(.LAST_STEP(4)) dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .run        (run),
      .opcode     (opcode),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .step       (step),
      .halted     (halted),
      .hlt        (hlt),
      .mi         (mi),
      .ri         (ri),
      .ro         (ro),
      .io         (io),
      .ii         (ii),
      .ai         (ai),
      .ao         (ao),
      .eo         (eo),
      .su         (su),
      .bi         (bi),
      .oi         (oi),
      .ce         (ce),
      .co         (co),
      .j          (j),
      .fi         (fi)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no summary, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_compared = 0;
   int n_failed   = 0;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r_n, input logic rn, input logic [3:0] op,
                        input logic cf, input logic zf);
      clear_n    = r_n;
      run        = rn;
      opcode     = op;
      carry_flag = cf;
      zero_flag  = zf;
   endtask

   // Inputs are driven 1 time unit after the rising edge; outputs are
   // sampled 3 units later, well away from either edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string name, input logic [2:0] st,
                               input logic hl, input logic [15:0] cw);
      #3;
      check({name, ".step"},   16'(step),   16'(st));
      check({name, ".halted"}, 16'(halted), 16'(hl));
      check({name, ".cw"},     cw_w,        cw);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        clear_n;
      logic        run;
      logic [3:0]  opcode;
      logic        cf;
      logic        zf;
      logic [2:0]  exp_step;
      logic        exp_halted;
      logic [15:0] exp_cw;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r_n, input logic rn, input logic [3:0] op,
                      input logic cf, input logic zf, input logic [2:0] st,
                      input logic hl, input logic [15:0] cw);
      vec_t v;
      v.clear_n = r_n; v.run = rn; v.opcode = op; v.cf = cf; v.zf = zf;
      v.exp_step = st; v.exp_halted = hl; v.exp_cw = cw;
      vecs.push_back(v);
   endtask

   // Queue an instruction starting at T0: fetch rows plus the given execute rows.
   task automatic add_fetch(input logic [3:0] op, input logic cf, input logic zf);
      add(1, 1, op, cf, zf, 3'd0, 0, FETCH0);
      add(1, 1, op, cf, zf, 3'd1, 0, FETCH1);
   endtask

   initial begin
      drive(0, 1, 4'h0, 0, 0);
      repeat (2) next_cycle();

      // Reset held with run=1: nothing asserted.
      add(0, 1, 4'h1, 0, 0, 3'd0, 0, 16'h0000);
      // LDA: 0,1,2,3 then back to 0
      add_fetch(4'h1, 0, 0);
      add(1, 1, 4'h1, 0, 0, 3'd2, 0, M_IO | M_MI);
      add(1, 1, 4'h1, 0, 0, 3'd3, 0, M_RO | M_AI);
      // SUB: 5 cycles, su only at T4
      add_fetch(4'h3, 0, 0);
      add(1, 1, 4'h3, 0, 0, 3'd2, 0, M_IO | M_MI);
      add(1, 1, 4'h3, 0, 0, 3'd3, 0, M_RO | M_BI);
      add(1, 1, 4'h3, 0, 0, 3'd4, 0, M_EO | M_AI | M_FI | M_SU);
      // ADD
      add_fetch(4'h2, 1, 1);
      add(1, 1, 4'h2, 1, 1, 3'd2, 0, M_IO | M_MI);
      add(1, 1, 4'h2, 1, 1, 3'd3, 0, M_RO | M_BI);
      add(1, 1, 4'h2, 1, 1, 3'd4, 0, M_EO | M_AI | M_FI);
      // JC taken / not taken (zf set to show flags are not crossed)
      add_fetch(4'h7, 1, 0);
      add(1, 1, 4'h7, 1, 0, 3'd2, 0, M_IO | M_J);
      add_fetch(4'h7, 0, 1);
      add(1, 1, 4'h7, 0, 1, 3'd2, 0, 16'h0000);
      // JZ taken / not taken
      add_fetch(4'h8, 0, 1);
      add(1, 1, 4'h8, 0, 1, 3'd2, 0, M_IO | M_J);
      add_fetch(4'h8, 1, 0);
      add(1, 1, 4'h8, 1, 0, 3'd2, 0, 16'h0000);
      // LDI, OUT, JMP
      add_fetch(4'h5, 0, 0);
      add(1, 1, 4'h5, 0, 0, 3'd2, 0, M_IO | M_AI);
      add_fetch(4'hE, 0, 0);
      add(1, 1, 4'hE, 0, 0, 3'd2, 0, M_AO | M_OI);
      add_fetch(4'h6, 0, 0);
      add(1, 1, 4'h6, 0, 0, 3'd2, 0, M_IO | M_J);
      // STA
      add_fetch(4'h4, 0, 0);
      add(1, 1, 4'h4, 0, 0, 3'd2, 0, M_IO | M_MI);
      add(1, 1, 4'h4, 0, 0, 3'd3, 0, M_AO | M_RI);
      // NOP and undefined opcode: empty T2, wrap after it
      add_fetch(4'h0, 1, 1);
      add(1, 1, 4'h0, 1, 1, 3'd2, 0, 16'h0000);
      add_fetch(4'hA, 0, 0);
      add(1, 1, 4'hA, 0, 0, 3'd2, 0, 16'h0000);
      add(1, 1, 4'hA, 0, 0, 3'd0, 0, FETCH0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].clear_n, vecs[i].run, vecs[i].opcode, vecs[i].cf, vecs[i].zf);
         expect_state($sformatf("vec%0d", i), vecs[i].exp_step, vecs[i].exp_halted,
                      vecs[i].exp_cw);
         next_cycle();
      end

      // ---------------- HLT ----------------
      // Resynchronise to T0.
      drive(0, 1, 4'hF, 0, 0);
      next_cycle();
      drive(1, 1, 4'hF, 0, 0);
      expect_state("hlt_t0", 3'd0, 0, FETCH0);
      next_cycle();
      expect_state("hlt_t1", 3'd1, 0, FETCH1);
      next_cycle();
      expect_state("hlt_t2", 3'd2, 0, M_HLT);
      next_cycle();
      for (int i = 0; i < 20; i++) begin
         // Program mode during the halt must not drop hlt.
         run = (i >= 8 && i < 11) ? 1'b0 : 1'b1;
         expect_state($sformatf("halted%0d", i), 3'd0, 1, M_HLT);
         next_cycle();
      end
      drive(0, 1, 4'hF, 0, 0);
      expect_state("hlt_clear", 3'd0, 1, 16'h0000);
      next_cycle();
      drive(1, 1, 4'h1, 0, 0);
      expect_state("hlt_refetch0", 3'd0, 0, FETCH0);
      next_cycle();
      expect_state("hlt_refetch1", 3'd1, 0, FETCH1);
      next_cycle();
      expect_state("hlt_refetch2", 3'd2, 0, M_IO | M_MI);
      next_cycle();
      expect_state("hlt_refetch3", 3'd3, 0, M_RO | M_AI);
      next_cycle();

      // ---------------- run drop during ADD T3 ----------------
      drive(1, 1, 4'h2, 0, 0);
      expect_state("prog_t0", 3'd0, 0, FETCH0);
      next_cycle();
      next_cycle();
      next_cycle();
      expect_state("prog_t3", 3'd3, 0, M_RO | M_BI);
      run = 1'b0;
      #1;
      check("prog_comb_off", cw_w, 16'h0000);
      next_cycle();
      expect_state("prog_idle", 3'd0, 0, 16'h0000);
      next_cycle();
      expect_state("prog_idle2", 3'd0, 0, 16'h0000);
      run = 1'b1;
      #1;
      check("prog_resume_t0", cw_w, FETCH0);
      next_cycle();
      expect_state("prog_resume_t1", 3'd1, 0, FETCH1);
      next_cycle();

      // ---------------- reset during STA T3 ----------------
      drive(0, 1, 4'h4, 0, 0);
      next_cycle();
      drive(1, 1, 4'h4, 0, 0);
      next_cycle();
      next_cycle();
      next_cycle();
      expect_state("sta_t3", 3'd3, 0, M_AO | M_RI);
      clear_n = 1'b0;
      #1;
      check("sta_ri_dropped", 16'(ri), 16'd0);
      check("sta_cw_dropped", cw_w, 16'h0000);
      next_cycle();
      expect_state("sta_after_reset", 3'd0, 0, 16'h0000);
      clear_n = 1'b1;
      #1;
      check("sta_refetch", cw_w, FETCH0);
      next_cycle();

      // ---------------- random run, one bus driver ----------------
      for (int i = 0; i < 1000; i++) begin
         // Opcode only changes before T2, where it is allowed to.
         if (step <= 3'd1) opcode = 4'($urandom_range(0, 14));
         carry_flag = 1'($urandom_range(0, 1));
         zero_flag  = 1'($urandom_range(0, 1));
         run        = ($urandom_range(0, 19) != 0);
         #3;
         check("bus_one_driver", 16'($countones({ro, io, ao, eo, co}) <= 1), 16'd1);
         check("step_bound", 16'(step <= 3'd4), 16'd1);
         next_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
